mem_dump_uart_tx: RTL and testbench
===================================

// Module: mem_dump_uart_tx
// PURPOSE
//  Streams a range of 32-bit words from a synchronous-read memory port out through the uart_tx core.
//  Each word is split into 4 bytes, least-significant byte first. This matches the byte order the
//  UART loader uses when it packs received bytes into words, so a memory image makes an exact round trip.
//  Pacing uses the uart_tx handshake (o_Tx_Active / o_Tx_Done), not a fixed byte-time counter.
//  Sits between the data memory and uart_tx on the 100 MHz board clock.
// PARAMETERS
//  MEM_SIZE  512  words in the memory; highest legal address is MEM_SIZE-1
//  ADDR_W    16   width of the memory address and of n_words
// PORTS
//  clk        in   1       system clock, 100 MHz
//  rst_n      in   1       reset, asynchronous, active-low
//  start      in   1       1-cycle pulse: begin a dump at address 0 (sampled only in IDLE)
//  n_words    in   ADDR_W  number of words to send, latched on start; 0 or >MEM_SIZE means MEM_SIZE
//  mem_addr   out  ADDR_W  memory read address
//  mem_rd_en  out  1       memory read enable
//  mem_rdata  in   32      read data, valid 1 cycle after mem_rd_en is sampled high
//  tx_dv      out  1       to uart_tx i_Tx_DV, 1-cycle pulse per byte
//  tx_byte    out  8       to uart_tx i_Tx_Byte; held stable from tx_dv until tx_done
//  tx_active  in   1       from uart_tx o_Tx_Active
//  tx_done    in   1       from uart_tx o_Tx_Done, 1-cycle pulse
//  busy       out  1       high from the cycle after an accepted start until FINISH
//  done       out  1       sticky high after a complete dump; cleared by the next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, async): every output is 0, FSM goes to IDLE, byte_idx=0, word_reg=0.
//    A byte already inside uart_tx may still complete; this block ignores it.
//  FSM states: IDLE, RD_REQ, RD_WAIT, LOAD, SEND, WAIT_DONE, NEXT, [CKSUM, CK_WAIT], FINISH.
//  IDLE:      on start, latch n_eff (n_words, or MEM_SIZE if 0 or >MEM_SIZE); set addr=0, done=0,
//             busy=1; go to RD_REQ.
//  RD_REQ:    mem_rd_en=1, mem_addr=addr; go to RD_WAIT. mem_rd_en is high in this state only.
//  RD_WAIT:   one cycle; go to LOAD.
//  LOAD:      word_reg <= mem_rdata; byte_idx <= 0; go to SEND.
//  SEND:      wait while tx_active=1. Otherwise: tx_byte <= word_reg[8*byte_idx +: 8];
//             tx_dv <= 1 for exactly 1 cycle; go to WAIT_DONE.
//  WAIT_DONE: wait for tx_done. Then, if byte_idx==3, go to NEXT; else byte_idx++ and go to SEND.
//  NEXT:      if addr==n_eff-1, go to CKSUM (when CHECKSUM_EN is defined) or FINISH.
//             Otherwise addr++ and go to RD_REQ.
//  FINISH:    done <= 1, busy <= 0; go to IDLE.
//  Per-word latency: 3 cycles (RD_REQ, RD_WAIT, LOAD) before the first tx_dv. The memory is read
//    once per word, never once per byte.
//  Boundaries:
//    - start while busy: ignored, with no effect on addr or n_eff.
//    - start in the same cycle as FINISH: ignored; start is accepted only in IDLE.
//    - tx_done outside WAIT_DONE: ignored.
//    - addr never exceeds MEM_SIZE-1 and never wraps.
//  tx_dv is never asserted while tx_active=1, and never twice without a tx_done in between.
// CONFIGURATION
//  CHECKSUM_EN defined:
//    - cksum, an 8-bit register, is cleared on an accepted start.
//    - cksum <= cksum + tx_byte (mod 256) on every tx_dv.
//    - After the last word: CKSUM state waits for ~tx_active, then sends cksum as one extra byte.
//      CK_WAIT waits for tx_done, then goes to FINISH.
//    - Total bytes sent = 4*n_eff + 1.
//  CHECKSUM_EN undefined: no cksum logic. Exactly 4*n_eff bytes are sent and NEXT goes straight to FINISH.
// TESTING
//  1 Byte order. mem[0]=32'h44332211, n_words=1, start.
//    -> tx_byte sequence 11,22,33,44; then done=1, busy=0.
//    -> with CHECKSUM_EN, a 5th byte 8'hAA.
//  2 Full dump. n_words=0, memory preloaded with mem[i]=i.
//    -> 2048 bytes, in order 00,00,00,00, 01,00,00,00, ...
//    -> last mem_addr=511; mem_rd_en pulses exactly 512 times.
//  3 Handshake. A uart_tx model holds tx_active high for 20 cycles per byte.
//    -> tx_dv never overlaps tx_active; exactly one tx_dv per tx_done; tx_byte stable until tx_done.
//  4 Start while busy. Pulse start again mid-dump with n_words=3.
//    -> no change; the original dump completes with its own byte count.
//  5 Reset mid-dump. Drop rst_n during WAIT_DONE of word 2.
//    -> all outputs 0 immediately; a new start dumps again from addr 0 with done cleared.
//  6 Clamp. n_words=700.
//    -> 512 words sent; mem_addr never exceeds 511.

Source files
------------

// File: rtl/mem_dump_uart_tx.sv
// Streams words 0..n_eff-1 from a sync-read memory to uart_tx, 4 bytes per word, LSB first.
// Optional trailing mod-256 checksum byte when CHECKSUM_EN is defined.
module mem_dump_uart_tx #(
  parameter int MEM_SIZE = 512,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_REQ    = 4'd1;
  localparam logic [3:0] S_RD_WAIT   = 4'd2;
  localparam logic [3:0] S_LOAD      = 4'd3;
  localparam logic [3:0] S_SEND      = 4'd4;
  localparam logic [3:0] S_WAIT_DONE = 4'd5;
  localparam logic [3:0] S_NEXT      = 4'd6;
`ifdef CHECKSUM_EN
  localparam logic [3:0] S_CKSUM     = 4'd7;
  localparam logic [3:0] S_CK_WAIT   = 4'd8;
`endif
  localparam logic [3:0] S_FINISH    = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] n_eff_q, n_eff_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] n_clamp;
  logic [7:0]        cur_byte;
`ifdef CHECKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  // A request of 0 or more words than exist means "the whole memory".
  assign n_clamp  = (n_words == '0 || n_words > ADDR_W'(MEM_SIZE)) ? ADDR_W'(MEM_SIZE) : n_words;
  assign cur_byte = word_q[{byte_idx_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    n_eff_d    = n_eff_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    tx_dv_d    = 1'b0;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_eff_d = n_clamp;
          addr_d  = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef CHECKSUM_EN
          cksum_d = 8'd0;
`endif
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        word_d     = mem_rdata;
        byte_idx_d = 2'd0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (!tx_active) begin
          tx_byte_d = cur_byte;
          tx_dv_d   = 1'b1;
`ifdef CHECKSUM_EN
          cksum_d   = cksum_q + cur_byte;
`endif
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_NEXT;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_SEND;
          end
        end
      end
      S_NEXT: begin
        if (addr_q == n_eff_q - ADDR_W'(1)) begin
`ifdef CHECKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_FINISH;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_REQ;
        end
      end
`ifdef CHECKSUM_EN
      S_CKSUM: begin
        if (!tx_active) begin
          tx_byte_d = cksum_q;
          tx_dv_d   = 1'b1;
          state_d   = S_CK_WAIT;
        end
      end
      S_CK_WAIT: begin
        if (tx_done) state_d = S_FINISH;
      end
`endif
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      n_eff_q    <= '0;
      word_q     <= '0;
      byte_idx_q <= 2'd0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CHECKSUM_EN
      cksum_q    <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      n_eff_q    <= n_eff_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state_q == S_RD_REQ);
  assign tx_dv     = tx_dv_q;
  assign tx_byte   = tx_byte_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_dump_uart_tx.sv
// Bench for mem_dump_uart_tx: table of dumps plus random dumps against a byte-stream model,
// with a latency-programmable uart_tx model and protocol monitor.
module tb_mem_dump_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_words = 16'd0;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = 32'd0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mem_dump_uart_tx #(.MEM_SIZE(512), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_words(n_words),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .done(done)
  );

  // Synchronous-read memory
  logic [31:0] mem [512];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr[8:0]];

  // uart_tx model: active for lat_cfg cycles after tx_dv, then a 1-cycle done
  int   lat_cfg = 1;
  int   ucnt = 0;
  logic uact = 1'b0;
  logic udone = 1'b0;
  logic spur_done = 1'b0;
  always @(posedge clk) begin
    udone <= 1'b0;
    if (tx_dv && !uact) begin
      uact <= 1'b1;
      ucnt <= lat_cfg;
    end else if (uact) begin
      if (ucnt <= 1) begin
        uact  <= 1'b0;
        udone <= 1'b1;
      end else ucnt <= ucnt - 1;
    end
  end
  assign tx_active = uact;
  assign tx_done   = udone | spur_done;

  // Monitor: captured bytes, read count, protocol violations
  logic [7:0] cap[$];
  int   rd_cnt = 0, viol = 0, last_rd = -1;
  logic pend = 1'b0;
  logic [7:0] held = 8'd0;
  always @(negedge clk) begin
    if (!rst_n) pend <= 1'b0;
    else begin
      if (tx_done) pend <= 1'b0;
      if (tx_dv) begin
        if (tx_active || pend) viol <= viol + 1;
        cap.push_back(tx_byte);
        pend <= 1'b1;
        held <= tx_byte;
      end else if (pend && tx_byte != held) viol <= viol + 1;
      if (mem_rd_en) begin
        rd_cnt  <= rd_cnt + 1;
        last_rd <= int'(mem_addr);
        if (mem_addr > 16'd511) viol <= viol + 1;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 512; i++) begin
      if (mode == 1) mem[i] = $urandom;
      else mem[i] = 32'(i);
    end
    if (mode == 2) mem[0] = 32'h44332211;
  endtask

  // Expected stream: n words LSB first, then optional checksum
  task automatic run_dump(input logic [15:0] nw, input int lat, input int exp_n,
                          input int mid, input string tag);
    int b0, r0, v0, bound, cyc, nbad, nexp;
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    sum = 8'd0;
    for (int w = 0; w < exp_n; w++)
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(mem[w][8*b +: 8]);
        sum = sum + mem[w][8*b +: 8];
      end
`ifdef CHECKSUM_EN
    exp_q.push_back(sum);
`endif
    @(negedge clk);
    lat_cfg = lat;
    b0 = cap.size(); r0 = rd_cnt; v0 = viol;
    n_words = nw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy/done after start"}, {62'd0, busy, done}, 64'h2);
    bound = exp_n * 4 * (lat + 8) + exp_n * 8 + lat + 200;
    cyc = 0;
    while (!done && cyc < bound) begin
      if (mid != 0 && cyc == mid) begin
        n_words = 16'd3; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, " completed in time"}, 64'(done), 64'd1);
    chk({tag, " busy low at end"}, 64'(busy), 64'd0);
    nexp = exp_q.size();
    chk({tag, " byte count"}, 64'(cap.size() - b0), 64'(nexp));
    nbad = 0;
    for (int i = 0; i < nexp; i++)
      if (b0 + i >= cap.size() || cap[b0 + i] !== exp_q[i]) begin
        if (nbad == 0 && b0 + i < cap.size())
          $display("  %s first wrong byte #%0d: %0h vs %0h", tag, i, cap[b0 + i], exp_q[i]);
        nbad++;
      end
    chk({tag, " byte values"}, 64'(nbad), 64'd0);
    chk({tag, " read pulses"}, 64'(rd_cnt - r0), 64'(exp_n));
    chk({tag, " last read addr"}, 64'(last_rd), 64'(exp_n - 1));
    chk({tag, " protocol"}, 64'(viol - v0), 64'd0);
  endtask

  typedef struct {
    logic [15:0] nw;
    int lat;
    int fill;
    int exp_n;
    int mid;
  } vec_t;

  vec_t vt[7];

  initial begin
    int b0, cnt;
    vt[0] = '{16'd1,   3,  2, 1,   0};
    vt[1] = '{16'd0,   1,  0, 512, 0};
    vt[2] = '{16'd2,   20, 1, 2,   0};
    vt[3] = '{16'd6,   2,  1, 6,   40};
    vt[4] = '{16'd700, 1,  1, 512, 0};
    vt[5] = '{16'd512, 1,  1, 512, 0};
    vt[6] = '{16'd5,   1,  1, 5,   0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {mem_addr, mem_rd_en, tx_dv, tx_byte, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      fill_mem(vt[v].fill);
      run_dump(vt[v].nw, vt[v].lat, vt[v].exp_n, vt[v].mid, $sformatf("vec%0d", v));
    end

    // tx_done while idle must be ignored
    b0 = cap.size();
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle spurious done", {62'd0, busy, done}, 64'h1);
    chk("idle no tx_dv", 64'(cap.size() - b0), 64'd0);

    // Reset during WAIT_DONE of word 2
    fill_mem(1);
    @(negedge clk);
    lat_cfg = 8; b0 = cap.size();
    n_words = 16'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (cap.size() - b0 < 9 && cnt < 2000) begin
      @(negedge clk); cnt++;
    end
    chk("reached word 2", 64'(cap.size() - b0 >= 9), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", {mem_addr, mem_rd_en, tx_dv, tx_byte, busy, done}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_dump(16'd4, 3, 4, 0, "after reset");

    // Random dumps
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      fill_mem(1);
      run_dump(16'(n), int'($urandom_range(1, 6)), n, 0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
